register_bank_sb: RTL and testbench
===================================

# register_bank_sb

Parametrised two-read/one-write register bank for the KGP-RISC datapath. It adds a per-register scoreboard (busy bits) so multi-cycle units can reserve a destination register at issue and release it on writeback. It sits between decode/issue, the ALU operand inputs (rData1/rData2) and the writeback mux output (wrData).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never marked busy
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- sr1, sr2  in  ADDR_W  read port indices
- rData1, rData2  out  DATA_W  read data, combinational from sr1/sr2
- busy1, busy2  out  1  scoreboard bit of sr1/sr2
- write  in  1  write enable
- dr  in  ADDR_W  write index
- wrData  in  DATA_W  write data
- rsv  in  1  reserve request for rsv_addr
- rsv_addr  in  ADDR_W  register to mark busy
- rsv_ok  out  1  reservation accepted this cycle (combinational)
- pend_count  out  ADDR_W+1  number of busy registers

## Operation
- Storage: 2**ADDR_W × DATA_W registers plus a 2**ADDR_W-bit busy vector.
- Write: at a rising edge with write=1 and reset=0, reg[dr] <= wrData and busy[dr] <= 0. Skipped when ZERO_REG=1 and dr=0.
- Reads are asynchronous: rData_n = reg[sr_n] and busy_n = busy[sr_n]. With ZERO_REG=1 and sr_n=0: rData_n=0 and busy_n=0.
- rsv_ok = rsv & (!busy[rsv_addr] | (write & dr==rsv_addr)). This blocks a WAW re-reservation but allows release-and-reserve of the same register in one cycle.
- With ZERO_REG=1 and rsv_addr=0: rsv_ok=rsv and no busy bit is set.
- Reservation: at a rising edge with rsv_ok=1, busy[rsv_addr] <= 1.
- Simultaneous write and reserve of the same register: the data is written and the busy bit ends at 1. The reserve wins.
- A rejected reservation (rsv=1, rsv_ok=0) has no effect. The requester holds rsv and retries.
- pend_count = popcount(busy vector), derived combinationally from registered bits.
- Write data is never checked against busy. Writing a non-busy register is legal, for example an immediate load.

## Timing
- Read latency is 0 cycles (combinational).
- A written value appears on rData the cycle after the write edge (without bypass).
- A busy bit set at edge N is visible on busy_n/pend_count after edge N. A busy bit cleared at edge N behaves the same way.
- Reset value of every output after the reset edge: rData1=rData2=0, busy1=busy2=0, pend_count=0.
- rsv_ok during reset follows its equation but has no effect.
- Reset mid-operation: all registers and busy bits clear at that edge. Concurrent write/rsv are ignored.
- Reset has priority over write and rsv.
- Same-edge write and reserve on different registers are independent.

## Configuration
- REGBANK_BYPASS_EN defined: when write=1 and dr==sr_n (excluding zero register under ZERO_REG), the read port forwards wrData combinationally. busy_n reads 0 in that cycle. This gives a same-cycle write-to-read forward.
- Undefined: read ports return only stored register contents and busy_n is the raw stored bit. A same-cycle write is seen on the next cycle.

## Test plan
- Reset, then write 370 to r1 and 4 to r2 on consecutive edges; set sr1=1, sr2=2 -> rData1=370, rData2=4, busy1=busy2=0, pend_count=0.
- With ZERO_REG=1, write 0xDEADBEEF to r0 and reserve r0 -> rData(sr=0)=0, rsv_ok=1, busy stays 0, pend_count=0.
- Reserve r3; next cycle reserve r3 again -> first rsv_ok=1 and busy[3]=1, pend_count=1; second rsv_ok=0. Then write 374 to r3 -> busy3=0, pend_count=0, rData=374.
- With r4 busy, assert write dr=4 wrData=7 and rsv rsv_addr=4 in the same cycle -> rsv_ok=1; afterwards reg[4]=7, busy[4]=1, pend_count=1.
- Reserve r5, r6, r7, then assert reset for one edge while write dr=5 -> all registers 0, busy all 0, pend_count=0, and the write is lost.
- Bypass: write dr=8 wrData=0x55 with sr1=8 in the same cycle -> with REGBANK_BYPASS_EN, rData1=0x55 and busy1=0 that cycle. Without it, rData1 shows the old value and updates to 0x55 next cycle.

Source files
------------

// File: rtl/register_bank_sb.sv
// Two-read/one-write register bank with a per-register busy scoreboard for multi-cycle destinations.
// Latency: reads, busy and rsv_ok are combinational; writes and reservations take effect at the next rising edge.
// Backpressure: rsv_ok low (register already busy, not being released) rejects a reservation; the requester holds rsv and retries.
// Optional feature: define REGBANK_BYPASS_EN to forward same-cycle write data to the read ports.

module register_bank_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] sr1,
   input  logic [ADDR_W-1:0] sr2,
   output logic [DATA_W-1:0] rData1,
   output logic [DATA_W-1:0] rData2,
   output logic              busy1,
   output logic              busy2,
   input  logic              write,
   input  logic [ADDR_W-1:0] dr,
   input  logic [DATA_W-1:0] wrData,
   input  logic              rsv,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              rsv_ok,
   output logic [ADDR_W:0]   pend_count
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam bit ZR    = (ZERO_REG != 0);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;

   logic wr_en;
   logic rsv_set;

   // Qualify write and reservation; register 0 is hardwired when ZR is set.
   always_comb begin
      wr_en   = write & ~(ZR & (dr == '0));
      // A register being released this cycle may be re-reserved immediately.
      rsv_ok  = rsv & (~busy_q[rsv_addr] | (write & (dr == rsv_addr)));
      rsv_set = rsv_ok & ~(ZR & (rsv_addr == '0));
   end

   // Next-state for storage and busy bits; reserve is applied last so it wins over a same-register release.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (wr_en) begin
         regs_d[dr] = wrData;
         busy_d[dr] = 1'b0;
      end
      if (rsv_set) begin
         busy_d[rsv_addr] = 1'b1;
      end
   end

   // State registers; synchronous reset overrides any concurrent write or reservation.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   // Read port 1: stored data, optionally forwarded from the in-flight write.
   always_comb begin
      rData1 = regs_q[sr1];
      busy1  = busy_q[sr1];
`ifdef REGBANK_BYPASS_EN
      if (wr_en && (dr == sr1)) begin
         rData1 = wrData;
         busy1  = 1'b0;
      end
`endif
      if (ZR && (sr1 == '0)) begin
         rData1 = '0;
         busy1  = 1'b0;
      end
   end

   // Read port 2: identical to port 1.
   always_comb begin
      rData2 = regs_q[sr2];
      busy2  = busy_q[sr2];
`ifdef REGBANK_BYPASS_EN
      if (wr_en && (dr == sr2)) begin
         rData2 = wrData;
         busy2  = 1'b0;
      end
`endif
      if (ZR && (sr2 == '0)) begin
         rData2 = '0;
         busy2  = 1'b0;
      end
   end

   // Number of outstanding reservations, from registered busy bits only.
   always_comb begin
      pend_count = '0;
      for (int i = 0; i < DEPTH; i++) begin
         pend_count = pend_count + (ADDR_W + 1)'(busy_q[i]);
      end
   end

endmodule

// File: tb/tb_register_bank_sb.sv
// Scoreboard bench for register_bank_sb: directed scenarios followed by random traffic.
// A driver applies stimulus and queues the expected outputs from a behavioural model.
// A monitor pops the queue on each falling edge and compares against the DUT.

module tb_register_bank_sb;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int ZERO_REG = 1;
   localparam int DEPTH    = 1 << ADDR_W;

   logic              clk;
   logic              reset;
   logic [ADDR_W-1:0] sr1, sr2;
   logic [DATA_W-1:0] rData1, rData2;
   logic              busy1, busy2;
   logic              write;
   logic [ADDR_W-1:0] dr;
   logic [DATA_W-1:0] wrData;
   logic              rsv;
   logic [ADDR_W-1:0] rsv_addr;
   logic              rsv_ok;
   logic [ADDR_W:0]   pend_count;

   register_bank_sb #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sr1       (sr1),
      .sr2       (sr2),
      .rData1    (rData1),
      .rData2    (rData2),
      .busy1     (busy1),
      .busy2     (busy2),
      .write     (write),
      .dr        (dr),
      .wrData    (wrData),
      .rsv       (rsv),
      .rsv_addr  (rsv_addr),
      .rsv_ok    (rsv_ok),
      .pend_count(pend_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic              b1;
      logic              b2;
      logic              ok;
      logic [ADDR_W:0]   pend;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];

   int compared   = 0;
   int mismatched = 0;

   // Behavioural model: register contents and which registers are reserved.
   logic [DATA_W-1:0] m_regs [DEPTH];
   bit                m_busy [DEPTH];

   function automatic bit is_zero_reg(input int a);
      return (ZERO_REG != 0) && (a == 0);
   endfunction

   function automatic int model_pending();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) if (m_busy[i]) n++;
      return n;
   endfunction

   function automatic void model_read(input int sr, input bit w, input int d, input logic [DATA_W-1:0] wd,
                                      output logic [DATA_W-1:0] data, output logic b);
      if (is_zero_reg(sr)) begin
         data = '0;
         b    = 1'b0;
      end else begin
         data = m_regs[sr];
         b    = m_busy[sr];
`ifdef REGBANK_BYPASS_EN
         if (w && d == sr) begin
            data = wd;
            b    = 1'b0;
         end
`endif
      end
   endfunction

   task automatic step(input bit r, input bit w, input int d, input logic [DATA_W-1:0] wd,
                       input bit rq, input int ra, input int s1, input int s2, input string nm);
      exp_t e;
      bit   accept;
      @(posedge clk);
      #1;
      reset    = r;
      write    = w;
      dr       = ADDR_W'(d);
      wrData   = wd;
      rsv      = rq;
      rsv_addr = ADDR_W'(ra);
      sr1      = ADDR_W'(s1);
      sr2      = ADDR_W'(s2);
      // A reservation is accepted unless the register is already reserved and not released this cycle.
      accept = rq && (!m_busy[ra] || (w && d == ra));
      model_read(s1, w, d, wd, e.rd1, e.b1);
      model_read(s2, w, d, wd, e.rd2, e.b2);
      e.ok   = accept;
      e.pend = (ADDR_W + 1)'(model_pending());
      exp_q.push_back(e);
      name_q.push_back(nm);
      // Apply the effect of the coming rising edge.
      if (r) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
         end
      end else begin
         if (w && !is_zero_reg(d)) begin
            m_regs[d] = wd;
            m_busy[d] = 0;
         end
         if (accept && !is_zero_reg(ra)) m_busy[ra] = 1;
      end
   endtask

   task automatic chk(input string nm, input string field, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, field, act, req);
      end
   endtask

   // Monitor: compare every queued expectation while the DUT outputs are stable.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, "rData1",     rData1, e.rd1);
            chk(nm, "rData2",     rData2, e.rd2);
            chk(nm, "busy1",      DATA_W'(busy1), DATA_W'(e.b1));
            chk(nm, "busy2",      DATA_W'(busy2), DATA_W'(e.b2));
            chk(nm, "rsv_ok",     DATA_W'(rsv_ok), DATA_W'(e.ok));
            chk(nm, "pend_count", DATA_W'(pend_count), DATA_W'(e.pend));
         end
      end
   end

   // Driver: directed scenarios, then random traffic.
   initial begin
      int wait_cycles;
      for (int i = 0; i < DEPTH; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 0;
      end
      reset = 1'b1; write = 1'b0; dr = '0; wrData = '0;
      rsv = 1'b0; rsv_addr = '0; sr1 = '0; sr2 = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      step(0, 0, 0, 0,            0, 0, 1, 2, "reset_state");
      step(0, 1, 1, 370,          0, 0, 1, 2, "wr_r1");
      step(0, 1, 2, 4,            0, 0, 1, 2, "wr_r2");
      step(0, 0, 0, 0,            0, 0, 1, 2, "rd_r1_r2");
      step(0, 1, 0, 32'hDEADBEEF, 1, 0, 0, 0, "r0_wr_rsv");
      step(0, 0, 0, 0,            0, 0, 0, 0, "r0_read");
      step(0, 0, 0, 0,            1, 3, 3, 0, "rsv_r3");
      step(0, 0, 0, 0,            1, 3, 3, 0, "rsv_r3_again");
      step(0, 1, 3, 374,          0, 0, 3, 0, "wr_r3");
      step(0, 0, 0, 0,            0, 0, 3, 0, "rd_r3");
      step(0, 0, 0, 0,            1, 4, 4, 0, "rsv_r4");
      step(0, 1, 4, 7,            1, 4, 4, 0, "wr_rsv_r4");
      step(0, 0, 0, 0,            0, 0, 4, 0, "rd_r4");
      step(0, 0, 0, 0,            1, 5, 5, 6, "rsv_r5");
      step(0, 0, 0, 0,            1, 6, 5, 6, "rsv_r6");
      step(0, 0, 0, 0,            1, 7, 5, 7, "rsv_r7");
      step(1, 1, 5, 32'h1234,     1, 9, 5, 6, "reset_mid");
      step(0, 0, 0, 0,            0, 0, 5, 7, "after_reset");
      step(0, 1, 8, 32'h11,       0, 0, 8, 0, "wr_r8_init");
      step(0, 1, 8, 32'h55,       0, 0, 8, 8, "bypass_r8");
      step(0, 0, 0, 0,            0, 0, 8, 8, "rd_r8");

      for (int n = 0; n < 600; n++) begin
         bit narrow;
         int hi;
         narrow = ($urandom_range(0, 3) != 0);
         hi     = narrow ? 7 : DEPTH - 1;
         step(($urandom_range(0, 60) == 0),
              ($urandom_range(0, 2) == 0),
              $urandom_range(0, hi),
              $urandom(),
              ($urandom_range(0, 1) == 0),
              $urandom_range(0, hi),
              $urandom_range(0, hi),
              $urandom_range(0, hi),
              "random");
      end

      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      if (exp_q.size() > 0) begin
         mismatched++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
